// File: rtl/if_stage_pkg.sv
// Shared bus types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    addr_t pc;
    word_t instr;
  } fqEntry_t;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } ifState_e;

  function automatic addr_t alignPc(input addr_t a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_fetch_queue.sv
// Synchronous FIFO of {pc, instr} entries; clear wins over push/pop.
module fetch_queue
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fqEntry_t                 pushData,
  input  logic                     pop,
  input  logic                     clear,
  output fqEntry_t                 headData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fqEntry_t        mem_r [DEPTH];
  logic [AW-1:0]   wrPtr_r;
  logic [AW-1:0]   rdPtr_r;
  logic [AW:0]     count_r;
  logic            doPush_s;
  logic            doPop_s;

  assign empty    = (count_r == '0);
  assign full     = (count_r == FULL_CNT);
  assign count    = count_r;
  assign headData = mem_r[rdPtr_r];
  assign doPop_s  = pop && !empty;
  assign doPush_s = push && (!full || doPop_s);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else if (clear) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else begin
      if (doPush_s) wrPtr_r <= wrPtr_r + AW'(1'b1);
      if (doPop_s)  rdPtr_r <= rdPtr_r + AW'(1'b1);
      count_r <= count_r + {{AW{1'b0}}, doPush_s} - {{AW{1'b0}}, doPop_s};
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (doPush_s && !clear) begin
      mem_r[wrPtr_r] <= pushData;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, in-order imem requests, fetch queue and IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_in,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FQ_DEPTH);

  ifState_e      state_r;
  addr_t         pc_r;
  logic [CW-1:0] osd_r, drop_r, osdNext_s, dropNext_s, fqCount_s;
  addr_t         ipc_r [FQ_DEPTH];
  logic [AW-1:0] ipcWr_r, ipcRd_r;
  logic          idValid_r;
  word_t         idInstr_r;
  addr_t         idPc_r;
  logic          fqEmpty_s, fqFull_s, fqPush_s, fqPop_s, popFree_s, issue_s, grant_s;
  logic [CW:0]   reserved_s, limit_s;
  fqEntry_t      fqHead_s, fqIn_s;

  // A head pop this cycle frees a slot, so the reservation may count it.
  assign popFree_s  = !stall_in && !fqEmpty_s;
  assign reserved_s = {1'b0, osd_r} + {1'b0, fqCount_s};
  assign limit_s    = {1'b0, DEPTH_C} + {{CW{1'b0}}, popFree_s};
  assign issue_s    = (state_r != ST_BOOT) && (reserved_s < limit_s) && (!fqFull_s || popFree_s);
  assign grant_s    = issue_s && imem_gnt;
  assign osdNext_s  = osd_r + {{AW{1'b0}}, grant_s} - {{AW{1'b0}}, imem_rvalid};
  assign fqPop_s    = !redirect_en && !stall_in;
  assign fqIn_s     = '{pc: ipc_r[ipcRd_r], instr: imem_rdata};

  assign imem_req  = issue_s;
  assign imem_addr = pc_r;
  assign id_valid  = idValid_r;
  assign id_instr  = idInstr_r;
  assign id_pc     = idPc_r;

  // Response routing: discard while draining, otherwise push into the queue.
  always_comb begin
    dropNext_s = drop_r;
    fqPush_s   = 1'b0;
    if (redirect_en) begin
      dropNext_s = osdNext_s;
    end else if (imem_rvalid) begin
      if (drop_r != '0) begin
        dropNext_s = drop_r - CW'(1'b1);
      end else begin
        fqPush_s = 1'b1;
      end
    end else begin
      dropNext_s = drop_r;
    end
  end

  // Issued-PC shadow queue, aligned with memory responses (dropped ones included).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FQ_DEPTH; i++) ipc_r[i] <= '0;
      ipcWr_r <= '0;
      ipcRd_r <= '0;
    end else begin
      if (grant_s) begin
        ipc_r[ipcWr_r] <= pc_r;
        ipcWr_r        <= ipcWr_r + AW'(1'b1);
      end
      if (imem_rvalid) ipcRd_r <= ipcRd_r + AW'(1'b1);
    end
  end

  // Control FSM, PC and IF/ID register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_BOOT;
      pc_r      <= RESET_PC;
      osd_r     <= '0;
      drop_r    <= '0;
      idValid_r <= 1'b0;
      idInstr_r <= INSTR_NOP;
      idPc_r    <= '0;
    end else begin
      osd_r  <= osdNext_s;
      drop_r <= dropNext_s;
      if (redirect_en) begin
        pc_r      <= alignPc(redirect_pc);
        state_r   <= (osdNext_s != '0) ? ST_FLUSH : ST_FETCH;
        idValid_r <= 1'b0;
        idInstr_r <= INSTR_NOP;
      end else begin
        if (grant_s) pc_r <= pc_r + 32'd4;
        case (state_r)
          ST_BOOT:  state_r <= ST_FETCH;
          ST_FETCH: state_r <= ST_FETCH;
          ST_FLUSH: state_r <= (dropNext_s == '0) ? ST_FETCH : ST_FLUSH;
          default:  state_r <= ST_BOOT;
        endcase
        if (!stall_in) begin
          if (!fqEmpty_s) begin
            idValid_r <= 1'b1;
            idPc_r    <= fqHead_s.pc;
            idInstr_r <= fqHead_s.instr;
          end else begin
            idValid_r <= 1'b0;
            idInstr_r <= INSTR_NOP;
          end
        end
      end
    end
  end

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_fq (
    .clk      (clk),
    .rst      (rst),
    .push     (fqPush_s),
    .pushData (fqIn_s),
    .pop      (fqPop_s),
    .clear    (redirect_en),
    .headData (fqHead_s),
    .count    (fqCount_s),
    .empty    (fqEmpty_s),
    .full     (fqFull_s)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order, fixed-latency memory model (instr = ~addr).
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall_in;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int          nChecks = 0;
  int          nFail   = 0;
  int          cyc     = 0;
  int          memLat  = 1;
  int          dueQ[$];
  logic [31:0] addrQ[$];
  int          n;

  if_stage #(.RESET_PC(32'h0000_3000), .FQ_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall_in    (stall_in),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic checkId(input string tag, input logic [31:0] pc);
    checkVal({tag, "_valid"}, 32'(id_valid), 32'd1);
    checkVal({tag, "_pc"}, id_pc, pc);
    checkVal({tag, "_instr"}, id_instr, ~pc);
  endtask

  task automatic checkBubble(input string tag, input logic [31:0] pc);
    checkVal({tag, "_valid"}, 32'(id_valid), 32'd0);
    checkVal({tag, "_instr"}, id_instr, 32'h0000_0000);
    checkVal({tag, "_pc"}, id_pc, pc);
  endtask

  task automatic memReset();
    dueQ.delete();
    addrQ.delete();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0000_0000;
  endtask

  // One clock: record a grant, advance, then drive the memory response for the new cycle.
  task automatic cycle();
    logic        granted;
    logic [31:0] a;
    granted = imem_req && imem_gnt && rst;
    a       = imem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (granted) begin
      dueQ.push_back(cyc + memLat - 1);
      addrQ.push_back(a);
    end
    if (dueQ.size() > 0 && dueQ[0] <= cyc) begin
      void'(dueQ.pop_front());
      imem_rdata  = ~addrQ.pop_front();
      imem_rvalid = 1'b1;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0000_0000;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; stall_in = 1'b0; redirect_en = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    #6;
    checkVal("rst_id_valid", 32'(id_valid), 32'd0);
    checkVal("rst_id_instr", id_instr, 32'h0);
    checkVal("rst_id_pc", id_pc, 32'h0);
    checkVal("rst_req", 32'(imem_req), 32'd0);
    checkVal("rst_addr", imem_addr, 32'h0000_3000);
    rst = 1'b1;
    #1;
    checkVal("boot_no_req", 32'(imem_req), 32'd0);

    // straight-line fetch, zero-wait memory
    cycle();
    checkVal("first_req", 32'(imem_req), 32'd1);
    checkVal("first_addr", imem_addr, 32'h0000_3000);
    cycle(); cycle();
    checkVal("fill_bubble", 32'(id_valid), 32'd0);
    cycle(); checkId("seq0", 32'h0000_3000);
    cycle(); checkId("seq1", 32'h0000_3004);
    cycle(); checkId("seq2", 32'h0000_3008);

    // stall while 0x3008 sits in ID: queue and outstanding slots fill, then no requests
    stall_in = 1'b1;
    #1;
    checkVal("stall_req_off", 32'(imem_req), 32'd0);
    checkVal("stall_addr", imem_addr, 32'h0000_3014);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checkId("stall_hold", 32'h0000_3008);
      checkVal("stall_req_held_off", 32'(imem_req), 32'd0);
    end
    stall_in = 1'b0;
    #1;
    checkVal("unstall_req", 32'(imem_req), 32'd1);
    cycle(); checkId("unstall0", 32'h0000_300C);
    cycle(); checkId("unstall1", 32'h0000_3010);

    // grant held low for 4 cycles drains the queue into bubbles
    imem_gnt = 1'b0;
    cycle(); checkId("gntlow0", 32'h0000_3014);
    checkVal("gntlow_addr", imem_addr, 32'h0000_301C);
    cycle(); checkId("gntlow1", 32'h0000_3018);
    cycle(); checkBubble("empty0", 32'h0000_3018);
    cycle(); checkBubble("empty1", 32'h0000_3018);
    imem_gnt = 1'b1;
    cycle(); checkVal("refill_bubble", 32'(id_valid), 32'd0);
    cycle(); cycle(); checkId("refill", 32'h0000_301C);

    // fresh start with latency-3 memory
    rst = 1'b0; memReset(); #1; rst = 1'b1;
    memLat = 3;
    cycle(); cycle(); cycle();

    // redirect with two outstanding, no grant and no response this cycle
    redirect_en = 1'b1; redirect_pc = 32'h0000_3102;
    #1;
    checkVal("redir1_no_req", 32'(imem_req), 32'd0);
    cycle();
    redirect_en = 1'b0;
    checkVal("redir1_addr", imem_addr, 32'h0000_3100);
    checkVal("redir1_bubble", 32'(id_valid), 32'd0);
    checkVal("redir1_drop", 32'(dut.drop_r), 32'd2);
    n = 0;
    while (!id_valid && n < 20) begin n++; cycle(); end
    checkVal("redir1_bubbles", 32'(n), 32'd6);
    checkId("redir1_target", 32'h0000_3100);

    // redirect in a cycle that also grants an old-PC request
    redirect_en = 1'b1; redirect_pc = 32'h0000_3200;
    #1;
    checkVal("redir2_req", 32'(imem_req), 32'd1);
    checkVal("redir2_old_addr", imem_addr, 32'h0000_310C);
    checkVal("redir2_osd_before", 32'(dut.osd_r), 32'd1);
    cycle();
    redirect_en = 1'b0;
    checkVal("redir2_drop", 32'(dut.drop_r), 32'd2);
    checkVal("redir2_osd", 32'(dut.osd_r), 32'd2);
    checkVal("redir2_addr", imem_addr, 32'h0000_3200);
    checkVal("redir2_bubble", 32'(id_valid), 32'd0);
    checkVal("redir2_nop", id_instr, 32'h0);
    n = 0;
    while (!id_valid && n < 20) begin n++; cycle(); end
    checkVal("redir2_bubbles", 32'(n), 32'd7);
    checkId("redir2_target", 32'h0000_3200);

    // async reset in the middle of a flush
    redirect_en = 1'b1; redirect_pc = 32'h0000_3300;
    cycle();
    redirect_en = 1'b0;
    checkVal("flush_state", 32'(dut.state_r), 32'(ST_FLUSH));
    #2;
    rst = 1'b0; memReset();
    #1;
    checkVal("arst_id_valid", 32'(id_valid), 32'd0);
    checkVal("arst_id_instr", id_instr, 32'h0);
    checkVal("arst_id_pc", id_pc, 32'h0);
    checkVal("arst_req", 32'(imem_req), 32'd0);
    checkVal("arst_addr", imem_addr, 32'h0000_3000);
    rst = 1'b1; memLat = 1;
    #1;
    cycle();
    checkVal("restart_req", 32'(imem_req), 32'd1);
    checkVal("restart_addr", imem_addr, 32'h0000_3000);
    cycle(); cycle(); cycle();
    checkId("restart_id", 32'h0000_3000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
